// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signal bundle for mem_arbiter.
// slave = arbiter view; master = requesters plus memory (testbench/top-level view).
interface mem_arbiter_if #(
    parameter int NREQ = 4,
    parameter int AW   = 12,
    parameter int DW   = 32
);
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    req_we;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    rvalid;
    logic [NREQ*DW-1:0] rdata;
    logic [AW-1:0]      mem_addr_a;
    logic [AW-1:0]      mem_addr_b;
    logic [DW-1:0]      mem_data_a;
    logic [DW-1:0]      mem_data_b;
    logic               mem_we_a;
    logic               mem_we_b;
    logic [DW-1:0]      mem_q_a;
    logic [DW-1:0]      mem_q_b;

    modport slave (
        input  req, req_we, req_addr, req_wdata, mem_q_a, mem_q_b,
        output gnt, rvalid, rdata,
               mem_addr_a, mem_addr_b, mem_data_a, mem_data_b, mem_we_a, mem_we_b
    );

    modport master (
        output req, req_we, req_addr, req_wdata, mem_q_a, mem_q_b,
        input  gnt, rvalid, rdata,
               mem_addr_a, mem_addr_b, mem_data_a, mem_data_b, mem_we_a, mem_we_b
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter granting up to two requesters per cycle onto a dual-port memory.
// Define MEM_ARB_FIXED_PRIO_EN for fixed priority (requester 0 highest, no pointer).
module mem_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 12,
    parameter int DW   = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    mem_arbiter_if.slave bus
);
    localparam int          PW     = $clog2(NREQ);
    localparam logic [PW:0] NREQ_W = (PW+1)'(NREQ);

    logic [PW-1:0]   w_start;
    logic [PW:0]     w_pos;
    logic [PW-1:0]   w_sel;
    logic            w_has_a;
    logic            w_has_b;
    logic [PW-1:0]   w_idx_a;
    logic [PW-1:0]   w_idx_b;
    logic            w_conflict;
    logic [NREQ-1:0] w_gnt;
    logic [NREQ-1:0] r_rvalid;
    logic [NREQ-1:0] r_rsel;

`ifdef MEM_ARB_FIXED_PRIO_EN
    assign w_start = '0;
`else
    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_last;
    logic [PW-1:0] w_ptr_nxt;

    assign w_start   = r_ptr;
    assign w_last    = w_has_b ? w_idx_b : w_idx_a;
    assign w_ptr_nxt = ({1'b0, w_last} == NREQ_W - 1'b1) ? '0 : w_last + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_has_a) begin
            r_ptr <= w_ptr_nxt;
        end
    end
`endif

    // Scan from w_start modulo NREQ; conflicting candidates for port B are skipped.
    always_comb begin
        w_has_a    = 1'b0;
        w_has_b    = 1'b0;
        w_idx_a    = '0;
        w_idx_b    = '0;
        w_pos      = '0;
        w_sel      = '0;
        w_conflict = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            w_pos = {1'b0, w_start} + (PW+1)'(k);
            if (w_pos >= NREQ_W) begin
                w_pos = w_pos - NREQ_W;
            end
            w_sel = w_pos[PW-1:0];
            w_conflict = (bus.req_addr[w_sel*AW +: AW] == bus.req_addr[w_idx_a*AW +: AW]) &&
                         (bus.req_we[w_sel] || bus.req_we[w_idx_a]);
            if (bus.req[w_sel] && rst_n) begin
                if (!w_has_a) begin
                    w_has_a = 1'b1;
                    w_idx_a = w_sel;
                end else if (!w_has_b && !w_conflict) begin
                    w_has_b = 1'b1;
                    w_idx_b = w_sel;
                end
            end
        end
    end

    always_comb begin
        w_gnt = '0;
        if (w_has_a) begin
            w_gnt[w_idx_a] = 1'b1;
        end
        if (w_has_b) begin
            w_gnt[w_idx_b] = 1'b1;
        end
    end

    assign bus.gnt        = w_gnt;
    assign bus.mem_addr_a = w_has_a ? bus.req_addr[w_idx_a*AW +: AW]  : '0;
    assign bus.mem_data_a = w_has_a ? bus.req_wdata[w_idx_a*DW +: DW] : '0;
    assign bus.mem_we_a   = w_has_a & bus.req_we[w_idx_a];
    assign bus.mem_addr_b = w_has_b ? bus.req_addr[w_idx_b*AW +: AW]  : '0;
    assign bus.mem_data_b = w_has_b ? bus.req_wdata[w_idx_b*DW +: DW] : '0;
    assign bus.mem_we_b   = w_has_b & bus.req_we[w_idx_b];

    // r_rsel[i]: 0 = read issued on port A, 1 = port B.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rvalid <= '0;
            r_rsel   <= '0;
        end else begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                r_rvalid[i] <= w_gnt[i] & ~bus.req_we[i];
                if (w_gnt[i]) begin
                    r_rsel[i] <= w_has_b && (w_idx_b == PW'(i));
                end
            end
        end
    end

    assign bus.rvalid = r_rvalid;

    always_comb begin
        bus.rdata = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (r_rvalid[i]) begin
                bus.rdata[i*DW +: DW] = r_rsel[i] ? bus.mem_q_b : bus.mem_q_a;
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, reset corner sequence, randomized run vs reference model.
module tb_mem_arbiter;
    localparam int NREQ = 4;
    localparam int AW   = 12;
    localparam int DW   = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

    mem_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Behavioural dual-port memory: synchronous write, synchronous (old-data) read.
    logic [DW-1:0] tbmem [0:4095];
    initial begin
        for (int i = 0; i < 4096; i++) tbmem[i] = '0;
    end
    always @(posedge clk) begin
        if (bus.mem_we_a) tbmem[bus.mem_addr_a] <= bus.mem_data_a;
        if (bus.mem_we_b) tbmem[bus.mem_addr_b] <= bus.mem_data_b;
        bus.mem_q_a <= tbmem[bus.mem_addr_a];
        bus.mem_q_b <= tbmem[bus.mem_addr_b];
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [3:0]        req;
        logic [3:0]        we;
        logic [3:0][11:0]  addr;
        logic [3:0][31:0]  wdata;
        logic [3:0]        gnt;
        logic [11:0]       aa;
        logic [11:0]       ab;
        logic              wea;
        logic              web;
        logic [3:0]        rv;
        logic [3:0][31:0]  rd;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] req, input logic [3:0] we,
                                input logic [3:0][11:0] addr, input logic [3:0][31:0] wdata,
                                input logic [3:0] gnt, input logic [11:0] aa, input logic [11:0] ab,
                                input logic wea, input logic web,
                                input logic [3:0] rv, input logic [3:0][31:0] rd);
        vec_t v;
        v.req = req; v.we = we; v.addr = addr; v.wdata = wdata;
        v.gnt = gnt; v.aa = aa; v.ab = ab; v.wea = wea; v.web = web;
        v.rv = rv; v.rd = rd;
        return v;
    endfunction

    task automatic drive(input logic [3:0] req, input logic [3:0] we,
                         input logic [3:0][11:0] addr, input logic [3:0][31:0] wdata);
        bus.req       = req;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
    endtask

    // Reference model state for the random phase (addresses 16..19 only).
    logic [DW-1:0]   ref_mem [4];
    int              m_ptr;
    logic [3:0]      exp_rv;
    logic [3:0][31:0] exp_rd;
    logic            act [4];
    logic            r_we [4];
    logic [11:0]     r_addr [4];
    logic [31:0]     r_wd [4];

    vec_t vecs[$];

    initial begin
        logic [3:0][11:0] ra;
        logic [3:0][31:0] rw;
        logic [3:0]       g, rv;
        logic [3:0][31:0] rd;
        logic [11:0]      aa, ab;
        int ga, gb, idx;

        // Directed table: ptr starts at 0 after reset.
        vecs.push_back(mk(4'b0011, 4'b0011, {12'd0, 12'd0, 12'd1, 12'd0}, {32'd0, 32'd0, 32'd720, 32'd1234},
                          4'b0011, 12'd0, 12'd1, 1'b1, 1'b1, 4'b0000, '0));
        vecs.push_back(mk(4'b1100, 4'b0000, {12'd0, 12'd1, 12'd0, 12'd0}, '0,
                          4'b1100, 12'd1, 12'd0, 1'b0, 1'b0, 4'b0000, '0));
        vecs.push_back(mk(4'b0011, 4'b0001, {12'd0, 12'd0, 12'd5, 12'd5}, {32'd0, 32'd0, 32'd0, 32'd55},
                          4'b0001, 12'd5, 12'd0, 1'b1, 1'b0, 4'b1100, {32'd1234, 32'd720, 32'd0, 32'd0}));
        vecs.push_back(mk(4'b0010, 4'b0000, {12'd0, 12'd0, 12'd5, 12'd0}, '0,
                          4'b0010, 12'd5, 12'd0, 1'b0, 1'b0, 4'b0000, '0));
        vecs.push_back(mk(4'b1000, 4'b1000, {12'd7, 12'd0, 12'd0, 12'd0}, {32'd4242, 32'd0, 32'd0, 32'd0},
                          4'b1000, 12'd7, 12'd0, 1'b1, 1'b0, 4'b0010, {32'd0, 32'd0, 32'd55, 32'd0}));
        for (int c = 0; c < 8; c++) begin
            g  = (c % 2 == 0) ? 4'b0011 : 4'b1100;
            aa = (c % 2 == 0) ? 12'd0 : 12'd5;
            ab = (c % 2 == 0) ? 12'd1 : 12'd9;
            if (c == 0) begin
                rv = 4'b0000; rd = '0;
            end else if (c % 2 == 1) begin
                rv = 4'b0011; rd = {32'd0, 32'd0, 32'd720, 32'd1234};
            end else begin
                rv = 4'b1100; rd = {32'd0, 32'd55, 32'd0, 32'd0};
            end
            vecs.push_back(mk(4'b1111, 4'b0000, {12'd9, 12'd5, 12'd1, 12'd0}, '0, g, aa, ab, 1'b0, 1'b0, rv, rd));
        end
        vecs.push_back(mk(4'b0110, 4'b0000, {12'd0, 12'd7, 12'd7, 12'd0}, '0,
                          4'b0110, 12'd7, 12'd7, 1'b0, 1'b0, 4'b1100, {32'd0, 32'd55, 32'd0, 32'd0}));
        vecs.push_back(mk(4'b0000, 4'b0000, '0, '0,
                          4'b0000, 12'd0, 12'd0, 1'b0, 1'b0, 4'b0110, {32'd0, 32'd4242, 32'd4242, 32'd0}));

        // Reset state with requests (including writes) pending.
        drive(4'b1111, 4'b1111, {12'd3, 12'd2, 12'd1, 12'd0}, '1);
        repeat (2) @(negedge clk);
        chk("rst_gnt", 128'(bus.gnt), 128'(4'b0000));
        chk("rst_we", 128'({bus.mem_we_a, bus.mem_we_b}), 128'(2'b00));
        chk("rst_rvalid", 128'(bus.rvalid), 128'(4'b0000));
        chk("rst_rdata", 128'(bus.rdata), 128'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;

        foreach (vecs[r]) begin
            drive(vecs[r].req, vecs[r].we, vecs[r].addr, vecs[r].wdata);
            @(negedge clk);
            chk($sformatf("v%0d_gnt", r), 128'(bus.gnt), 128'(vecs[r].gnt));
            chk($sformatf("v%0d_addr", r), 128'({bus.mem_addr_a, bus.mem_addr_b}), 128'({vecs[r].aa, vecs[r].ab}));
            chk($sformatf("v%0d_we", r), 128'({bus.mem_we_a, bus.mem_we_b}), 128'({vecs[r].wea, vecs[r].web}));
            chk($sformatf("v%0d_rvalid", r), 128'(bus.rvalid), 128'(vecs[r].rv));
            chk($sformatf("v%0d_rdata", r), 128'(bus.rdata), 128'(vecs[r].rd));
            @(posedge clk); #1;
        end

        // Reset in the cycle after a read grant (ptr is 3 here).
        drive(4'b0001, 4'b0000, '0, '0);
        @(negedge clk);
        chk("mr_gnt", 128'(bus.gnt), 128'(4'b0001));
        @(posedge clk); #1;
        rst_n = 1'b0;
        bus.req_we = 4'b0001;
        #1;
        chk("mr_rvalid", 128'(bus.rvalid), 128'(4'b0000));
        chk("mr_gnt_rst", 128'(bus.gnt), 128'(4'b0000));
        chk("mr_we_rst", 128'(bus.mem_we_a), 128'(1'b0));
        @(negedge clk);
        chk("mr_gnt_hold", 128'(bus.gnt), 128'(4'b0000));
        @(posedge clk); #1;
        chk("mr_rvalid_hold", 128'(bus.rvalid), 128'(4'b0000));
        rst_n = 1'b1;
        drive(4'b1001, 4'b0000, {12'd7, 12'd0, 12'd0, 12'd0}, '0);
        @(negedge clk);
        chk("mr_ptr_gnt", 128'(bus.gnt), 128'(4'b1001));
        chk("mr_ptr_addr", 128'({bus.mem_addr_a, bus.mem_addr_b}), 128'({12'd0, 12'd7}));
        @(posedge clk); #1;
        drive(4'b0000, 4'b0000, '0, '0);
        @(negedge clk);
        chk("mr_rvalid2", 128'(bus.rvalid), 128'(4'b1001));
        chk("mr_rdata2", 128'(bus.rdata), 128'({32'd4242, 32'd0, 32'd0, 32'd1234}));

        // Randomized phase against the reference model.
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_ptr = 0;
        exp_rv = '0;
        exp_rd = '0;
        for (int i = 0; i < 4; i++) begin
            ref_mem[i] = '0;
            act[i] = 1'b0;
        end
        for (int cyc = 0; cyc < 300; cyc++) begin
            for (int i = 0; i < 4; i++) begin
                if (!act[i] && $urandom_range(0, 9) < 6) begin
                    act[i]    = 1'b1;
                    r_we[i]   = ($urandom_range(0, 2) == 0);
                    r_addr[i] = 12'(16 + $urandom_range(0, 3));
                    r_wd[i]   = $urandom;
                end
            end
            for (int i = 0; i < 4; i++) begin
                ra[i] = act[i] ? r_addr[i] : 12'd0;
                rw[i] = act[i] ? r_wd[i] : 32'd0;
                g[i]  = act[i];
                rv[i] = act[i] & r_we[i];
            end
            drive(g, rv, ra, rw);

            ga = -1;
            gb = -1;
            for (int k = 0; k < 4; k++) begin
                idx = (m_ptr + k) % 4;
                if (act[idx]) begin
                    if (ga < 0) ga = idx;
                    else if (gb < 0 && !(r_addr[idx] == r_addr[ga] && (r_we[idx] || r_we[ga]))) gb = idx;
                end
            end
            g = '0;
            if (ga >= 0) g[ga] = 1'b1;
            if (gb >= 0) g[gb] = 1'b1;

            @(negedge clk);
            chk("rnd_gnt", 128'(bus.gnt), 128'(g));
            chk("rnd_port_a", 128'({bus.mem_addr_a, bus.mem_data_a, bus.mem_we_a}),
                ga >= 0 ? 128'({r_addr[ga], r_wd[ga], r_we[ga]}) : 128'(0));
            chk("rnd_port_b", 128'({bus.mem_addr_b, bus.mem_data_b, bus.mem_we_b}),
                gb >= 0 ? 128'({r_addr[gb], r_wd[gb], r_we[gb]}) : 128'(0));
            chk("rnd_rvalid", 128'(bus.rvalid), 128'(exp_rv));
            chk("rnd_rdata", 128'(bus.rdata), 128'(exp_rd));
            @(posedge clk); #1;

            exp_rv = '0;
            exp_rd = '0;
            for (int i = 0; i < 4; i++) begin
                if (g[i] && !r_we[i]) begin
                    exp_rv[i] = 1'b1;
                    exp_rd[i] = ref_mem[r_addr[i] - 12'd16];
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (g[i]) begin
                    if (r_we[i]) ref_mem[r_addr[i] - 12'd16] = r_wd[i];
                    act[i] = 1'b0;
                end
            end
            if (ga >= 0) m_ptr = ((gb >= 0 ? gb : ga) + 1) % 4;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
